// File: rtl/adaptive_thresh_win.sv
// adaptive_thresh_win
//   Streaming 5x5 adaptive threshold over a raster image. Each interior pixel is compared
//   against the mean-like level (window sum >> SHIFT) + offset, against a fixed threshold,
//   both, or passed through unchanged. Border pixels (two-pixel margin) are not emitted.
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_valid, i_sof       input pixel qualifier, start of frame (pixel (0,0))
//   i_pix                raster-order input pixel
//   i_mode               0 adaptive, 1 fixed, 2 pass-through, 3 adaptive and fixed
//   i_thr, i_offset      fixed threshold (unsigned), signed level offset; sampled at i_sof
//   o_valid/o_sof/o_eof  output strobe, first/last output of a frame
//   o_pix                result pixel
module adaptive_thresh_win #(
   parameter int unsigned DW    = 8,
   parameter int unsigned IMG_W = 256,
   parameter int unsigned IMG_H = 256,
   parameter int unsigned SHIFT = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_valid,
   input  logic          i_sof,
   input  logic [DW-1:0] i_pix,
   input  logic [1:0]    i_mode,
   input  logic [DW-1:0] i_thr,
   input  logic [DW:0]   i_offset,
   output logic          o_valid,
   output logic          o_sof,
   output logic          o_eof,
   output logic [DW-1:0] o_pix
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam int unsigned SW = DW + 5;

   // Position counters, frame-active flag and per-frame configuration
   logic [CW-1:0] col_q, col_d, cur_col;
   logic [RW-1:0] row_q, row_d, cur_row;
   logic          active_q, active_d;
   logic [1:0]    mode_q, mode_d;
   logic [DW-1:0] thr_q, thr_d;
   logic [DW:0]   off_q, off_d;

   logic take, last_pix, trig, trig_sof, trig_eof;

   // Line buffers and window: no reset needed, only interior (fully written) windows are used
   logic [DW-1:0] lb_q  [4][IMG_W];
   logic [DW-1:0] win_q [5][5];

   // Pipeline stages
   logic          v0_q, sof0_q, eof0_q;
   logic          v1_q, sof1_q, eof1_q;
   logic [SW-1:0] sum_d, sum_q;
   logic [DW-1:0] ctr_q;
   logic [1:0]    mode1_q;
   logic [DW-1:0] thr1_q;
   logic [DW:0]   off1_q;

   logic          ovalid_q, osof_q, oeof_q;
   logic [DW-1:0] opix_q, res;

   logic [SW-1:0] sum_sh;
   logic [SW+1:0] lvl_w;
   logic [DW-1:0] lvl;
   logic          ge_lvl, ge_thr;

   // An accepted sof restarts at (0,0) whatever the counters hold
   always_comb begin
      cur_col  = i_sof ? '0 : col_q;
      cur_row  = i_sof ? '0 : row_q;
      take     = i_valid && (i_sof || active_q);
      last_pix = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
      trig     = take && (cur_row >= RW'(4)) && (cur_col >= CW'(4));
      trig_sof = trig && (cur_row == RW'(4)) && (cur_col == CW'(4));
      trig_eof = trig && last_pix;
   end

   always_comb begin
      col_d    = col_q;
      row_d    = row_q;
      active_d = active_q;
      mode_d   = mode_q;
      thr_d    = thr_q;
      off_d    = off_q;
      if (i_valid && i_sof) begin
         mode_d   = i_mode;
         thr_d    = i_thr;
         off_d    = i_offset;
         active_d = 1'b1;
      end
      if (take) begin
         if (last_pix) begin
            col_d    = '0;
            row_d    = '0;
            active_d = 1'b0;
         end else if (cur_col == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = cur_row + RW'(1);
         end else begin
            col_d = cur_col + CW'(1);
            row_d = cur_row;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         col_q    <= '0;
         row_q    <= '0;
         active_q <= 1'b0;
         mode_q   <= 2'd0;
         thr_q    <= '0;
         off_q    <= '0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         active_q <= active_d;
         mode_q   <= mode_d;
         thr_q    <= thr_d;
         off_q    <= off_d;
      end
   end

   // Window rows: 4 = current line, 0 = four lines up; column 4 is the newest pixel
   always_ff @(posedge i_clk) begin
      if (take) begin
         lb_q[0][cur_col] <= i_pix;
         for (int k = 1; k < 4; k++) lb_q[k][cur_col] <= lb_q[k-1][cur_col];
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) win_q[r][c] <= win_q[r][c+1];
         end
         win_q[4][4] <= i_pix;
         for (int k = 0; k < 4; k++) win_q[3-k][4] <= lb_q[k][cur_col];
      end
   end

   always_comb begin
      sum_d = '0;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) sum_d = sum_d + SW'(win_q[r][c]);
      end
   end

   // Level = (sum >> SHIFT) + offset, evaluated two bits wider than the sum so the sign
   // and any overflow above the pixel range are both visible for saturation
   always_comb begin
      sum_sh = sum_q >> SHIFT;
      lvl_w  = {2'b00, sum_sh} + {{(SW + 1 - DW){off1_q[DW]}}, off1_q};
      if (lvl_w[SW+1])          lvl = '0;
      else if (|lvl_w[SW:DW])   lvl = '1;
      else                      lvl = lvl_w[DW-1:0];
      ge_lvl = (ctr_q >= lvl);
      ge_thr = (ctr_q >= thr1_q);
      res    = '0;
      unique case (mode1_q)
         2'd0:    res = ge_lvl ? '1 : '0;
         2'd1:    res = ge_thr ? '1 : '0;
         2'd2:    res = ctr_q;
         default: res = (ge_lvl && ge_thr) ? '1 : '0;
      endcase
   end

   // Stage 1 carries its own copy of the config so outputs in flight across a new sof
   // still use the configuration of the frame they belong to
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v0_q     <= 1'b0;
         sof0_q   <= 1'b0;
         eof0_q   <= 1'b0;
         v1_q     <= 1'b0;
         sof1_q   <= 1'b0;
         eof1_q   <= 1'b0;
         sum_q    <= '0;
         ctr_q    <= '0;
         mode1_q  <= 2'd0;
         thr1_q   <= '0;
         off1_q   <= '0;
         ovalid_q <= 1'b0;
         osof_q   <= 1'b0;
         oeof_q   <= 1'b0;
         opix_q   <= '0;
      end else begin
         v0_q     <= trig;
         sof0_q   <= trig_sof;
         eof0_q   <= trig_eof;
         v1_q     <= v0_q;
         sof1_q   <= sof0_q;
         eof1_q   <= eof0_q;
         if (v0_q) begin
            sum_q   <= sum_d;
            ctr_q   <= win_q[2][2];
            mode1_q <= mode_q;
            thr1_q  <= thr_q;
            off1_q  <= off_q;
         end
         ovalid_q <= v1_q;
         osof_q   <= v1_q && sof1_q;
         oeof_q   <= v1_q && eof1_q;
         if (v1_q) opix_q <= res;
      end
   end

   assign o_valid = ovalid_q;
   assign o_sof   = osof_q;
   assign o_eof   = oeof_q;
   assign o_pix   = opix_q;

endmodule

// File: tb/tb_adaptive_thresh_win.sv
// Directed bench for adaptive_thresh_win at 8x8, DW=8, SHIFT=4. Frames are described by a
// table of {config, pattern, expected even/odd-centre result}; the driver derives each
// expected output (cycle, pixel, sof, eof) and a negedge monitor records what emerges.
module tb_adaptive_thresh_win;

   localparam int IMG = 8;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] thr;
      logic [8:0] off;
      int         pat;     // 0 constant base, 1 checkerboard 128/127
      int         base;
      bit         gaps;
      logic [7:0] e_even;  // expected result where (r+c) is even
      logic [7:0] e_odd;
   } vec_t;

   typedef struct {
      int         cyc;
      logic [7:0] pix;
      logic       sof;
      logic       eof;
   } rec_t;

   logic       clk = 1'b0, rst_n = 1'b1, valid = 1'b0, sof = 1'b0;
   logic [7:0] pix = '0, thr = '0;
   logic [1:0] mode = '0;
   logic [8:0] off = '0;
   logic       o_valid, o_sof, o_eof;
   logic [7:0] o_pix;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   rec_t exp_q[$];
   rec_t obs_q[$];
   vec_t vecs[12];

   adaptive_thresh_win #(.DW(8), .IMG_W(IMG), .IMG_H(IMG), .SHIFT(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_sof(sof), .i_pix(pix),
      .i_mode(mode), .i_thr(thr), .i_offset(off),
      .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof), .o_pix(o_pix)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (o_valid) obs_q.push_back('{cyc, o_pix, o_sof, o_eof});
   end

   task automatic chk(input string nm, input int got, input int expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, expv);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         valid = 1'b0;
         sof   = 1'b0;
      end
   endtask

   // Sends the first npix raster pixels; config changes after the sof pixel must be ignored
   task automatic send_frame(input logic [1:0] m, input logic [7:0] t, input logic [8:0] o,
                             input int pat, input int base, input bit gaps, input int npix,
                             input bit with_sof, input logic [7:0] ee, input logic [7:0] eo);
      for (int k = 0; k < npix; k++) begin
         int r, c;
         r = k / IMG;
         c = k % IMG;
         if (gaps && k > 0) begin
            int g;
            g = $urandom_range(0, 2);
            for (int j = 0; j < g; j++) begin
               @(negedge clk);
               valid = 1'b0;
               sof   = 1'($urandom_range(0, 1));
               pix   = 8'($urandom_range(0, 255));
            end
         end
         @(negedge clk);
         valid = 1'b1;
         sof   = with_sof && (k == 0);
         pix   = (pat == 1) ? (((r + c) % 2 == 0) ? 8'd128 : 8'd127) : 8'(base);
         if (with_sof && k == 0) begin
            mode = m;
            thr  = t;
            off  = o;
         end else if (with_sof && k == 1) begin
            mode = ~m;
            thr  = ~t;
            off  = ~o;
         end
         if (with_sof && r >= 4 && c >= 4) begin
            exp_q.push_back('{cyc + 3, ((r + c) % 2 == 0) ? ee : eo,
                              (r == 4) && (c == 4), (r == IMG - 1) && (c == IMG - 1)});
         end
      end
   endtask

   task automatic drain(input string nm);
      int n;
      idle(6);
      chk($sformatf("%s.count", nm), obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s[%0d].cyc", nm, i), obs_q[i].cyc, exp_q[i].cyc);
         chk($sformatf("%s[%0d].pix", nm, i), int'(obs_q[i].pix), int'(exp_q[i].pix));
         chk($sformatf("%s[%0d].sof", nm, i), int'(obs_q[i].sof), int'(exp_q[i].sof));
         chk($sformatf("%s[%0d].eof", nm, i), int'(obs_q[i].eof), int'(exp_q[i].eof));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rec_t tmp;
      // mode, thr, offset, pattern, base, gaps, expected even, expected odd
      vecs[0]  = '{2'd0, 8'd0,   9'd0,    0, 100, 1'b0, 8'd0,   8'd0};   // level 156
      vecs[1]  = '{2'd1, 8'd128, 9'd0,    1, 0,   1'b0, 8'd255, 8'd0};
      vecs[2]  = '{2'd0, 8'd0,   9'd10,   0, 255, 1'b0, 8'd255, 8'd255}; // level clamps 255
      vecs[3]  = '{2'd0, 8'd0,   9'h1FB,  0, 0,   1'b0, 8'd255, 8'd255}; // -5 clamps to 0
      vecs[4]  = '{2'd0, 8'd0,   9'h1B9,  1, 0,   1'b0, 8'd255, 8'd0};   // 199-71 = 128
      vecs[5]  = '{2'd0, 8'd0,   9'h1B8,  1, 0,   1'b0, 8'd255, 8'd255}; // 199-72 = 127
      vecs[6]  = '{2'd3, 8'd128, 9'h1B0,  1, 0,   1'b0, 8'd255, 8'd0};   // level 119 and thr
      vecs[7]  = '{2'd2, 8'd0,   9'd0,    1, 0,   1'b0, 8'd128, 8'd127};
      vecs[8]  = '{2'd1, 8'd128, 9'd0,    1, 0,   1'b1, 8'd255, 8'd0};
      vecs[9]  = '{2'd0, 8'd0,   9'd0,    0, 100, 1'b1, 8'd0,   8'd0};
      vecs[10] = '{2'd1, 8'd100, 9'd0,    0, 100, 1'b0, 8'd255, 8'd255};
      vecs[11] = '{2'd1, 8'd101, 9'd0,    0, 100, 1'b1, 8'd0,   8'd0};

      #2 rst_n = 1'b0;
      #3;
      chk("rst.valid", o_valid, 0);
      chk("rst.sof", o_sof, 0);
      chk("rst.eof", o_eof, 0);
      chk("rst.pix", o_pix, 0);
      idle(2);
      rst_n = 1'b1;

      // Pixels before the first sof are ignored
      send_frame(2'd2, 8'd0, 9'd0, 0, 50, 1'b0, 64, 1'b0, 8'd0, 8'd0);
      drain("pre_sof");

      foreach (vecs[i]) begin
         send_frame(vecs[i].mode, vecs[i].thr, vecs[i].off, vecs[i].pat, vecs[i].base,
                    vecs[i].gaps, 64, 1'b1, vecs[i].e_even, vecs[i].e_odd);
         drain($sformatf("vec%0d", i));
      end

      // Pixels after the frame end and before the next sof are ignored
      send_frame(2'd2, 8'd0, 9'd0, 0, 9, 1'b0, 20, 1'b0, 8'd0, 8'd0);
      drain("post_eof");

      // New sof at pixel 30, then a full frame with the new config
      send_frame(2'd2, 8'd0, 9'd0, 0, 100, 1'b0, 30, 1'b1, 8'd100, 8'd100);
      send_frame(2'd0, 8'd0, 9'd0, 0, 100, 1'b0, 64, 1'b1, 8'd0, 8'd0);
      drain("abort30");

      // New sof right behind two triggers: both emerge with the old pass-through config
      send_frame(2'd2, 8'd0, 9'd0, 0, 77, 1'b0, 38, 1'b1, 8'd77, 8'd77);
      send_frame(2'd1, 8'd128, 9'd0, 1, 0, 1'b0, 64, 1'b1, 8'd255, 8'd0);
      drain("abort_inflight");

      // Reset while an output is showing; the second in-flight output is lost
      send_frame(2'd2, 8'd0, 9'd0, 0, 100, 1'b0, 38, 1'b1, 8'd100, 8'd100);
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      chk("pre_rst.valid", o_valid, 1);
      chk("pre_rst.pix", o_pix, 100);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst.valid", o_valid, 0);
      chk("async_rst.pix", o_pix, 0);
      chk("async_rst.sof", o_sof, 0);
      chk("async_rst.eof", o_eof, 0);
      tmp = exp_q.pop_back();
      idle(2);
      rst_n = 1'b1;
      drain("mid_rst");
      send_frame(2'd2, 8'd0, 9'd0, 0, 60, 1'b0, 64, 1'b0, 8'd0, 8'd0);
      drain("after_rst_nosof");
      send_frame(2'd1, 8'd128, 9'd0, 1, 0, 1'b1, 64, 1'b1, 8'd255, 8'd0);
      drain("after_rst_frame");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
